// File: rtl/life_engine_param.sv
// Parametrised Game of Life engine: row-serial next-generation compute into a
// shadow board, single-cycle commit, optional toroidal wrap, free-run mode and
// still-life / extinction flags.
module life_engine_param #(
  parameter  int unsigned ROWS  = 16,
  parameter  int unsigned COLS  = 16,
  parameter  int unsigned GEN_W = 16,
  localparam int unsigned RW    = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load_valid,
  input  logic [RW-1:0]        load_row,
  input  logic [COLS-1:0]      load_data,
  input  logic                 step,
  input  logic                 run,
  input  logic                 wrap_mode,
  output logic [ROWS*COLS-1:0] board_o,
  output logic [GEN_W-1:0]     generation_cnt_o,
  output logic                 busy,
  output logic                 done,
  output logic                 stable,
  output logic                 extinct
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                     state;
  logic [RW-1:0]              row_idx;
  logic                       wrap_q;
  logic [ROWS-1:0][COLS-1:0]  board;
  logic [ROWS-1:0][COLS-1:0]  shadow;
  logic [GEN_W-1:0]           gen;

  logic [COLS-1:0]            row_up;
  logic [COLS-1:0]            row_mid;
  logic [COLS-1:0]            row_dn;
  logic [COLS+1:0]            ext_up;
  logic [COLS+1:0]            ext_mid;
  logic [COLS+1:0]            ext_dn;
  logic [3:0]                 cnt;
  logic [COLS-1:0]            next_row;

  assign board_o          = board;
  assign generation_cnt_o = gen;

  // Fetch the three source rows around row_idx; off-board rows are dead unless wrapping
  always_comb begin
    row_mid = board[row_idx];
    if (row_idx == '0) begin
      row_up = wrap_q ? board[LAST_ROW] : '0;
    end else begin
      row_up = board[row_idx - RW'(1)];
    end
    if (row_idx == LAST_ROW) begin
      row_dn = wrap_q ? board[0] : '0;
    end else begin
      row_dn = board[row_idx + RW'(1)];
    end
  end

  // Pad each row by one column on both sides so every cell sees a uniform 3x3 window
  always_comb begin
    ext_up  = {wrap_q & row_up[0],  row_up,  wrap_q & row_up[COLS-1]};
    ext_mid = {wrap_q & row_mid[0], row_mid, wrap_q & row_mid[COLS-1]};
    ext_dn  = {wrap_q & row_dn[0],  row_dn,  wrap_q & row_dn[COLS-1]};
  end

  // B3/S23 rule applied to every column of the current row
  always_comb begin
    cnt      = '0;
    next_row = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      cnt = 4'(ext_up[c])  + 4'(ext_up[c+1])  + 4'(ext_up[c+2]) +
            4'(ext_mid[c])                    + 4'(ext_mid[c+2]) +
            4'(ext_dn[c])  + 4'(ext_dn[c+1])  + 4'(ext_dn[c+2]);
      next_row[c] = (cnt == 4'd3) | (ext_mid[c+1] & (cnt == 4'd2));
    end
  end

  // Control FSM plus board, shadow, counter and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_idx <= '0;
      wrap_q  <= 1'b0;
      board   <= '0;
      shadow  <= '0;
      gen     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      stable  <= 1'b0;
      extinct <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        row_idx <= '0;
        board   <= '0;
        gen     <= '0;
        busy    <= 1'b0;
        stable  <= 1'b0;
        extinct <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load_valid) begin
              if (32'(load_row) < ROWS) begin
                board[load_row] <= load_data;
                stable          <= 1'b0;
                extinct         <= 1'b0;
              end
            end else if (step || run) begin
              wrap_q  <= wrap_mode;
              row_idx <= '0;
              busy    <= 1'b1;
              state   <= COMPUTE;
            end
          end
          COMPUTE: begin
            shadow[row_idx] <= next_row;
            if (row_idx == LAST_ROW) begin
              state <= COMMIT;
            end else begin
              row_idx <= row_idx + RW'(1);
            end
          end
          COMMIT: begin
            board   <= shadow;
            gen     <= gen + GEN_W'(1);
            stable  <= (shadow == board);
            extinct <= (shadow == '0);
            done    <= 1'b1;
            if (run) begin
              wrap_q  <= wrap_mode;
              row_idx <= '0;
              state   <= COMPUTE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_life_engine_param.sv
// Directed + randomized bench for life_engine_param against an array-based Life model.
module tb_life_engine_param;

  localparam int R = 16;
  localparam int C = 16;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         load_valid;
  logic [3:0]   load_row;
  logic [15:0]  load_data;
  logic         step;
  logic         run;
  logic         wrap_mode;

  logic [255:0] board_o;
  logic [15:0]  gen_o;
  logic         busy, done, stable, extinct;
  logic [255:0] board4;
  logic [3:0]   gen4;
  logic         busy4, done4, stable4, extinct4;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit m [R][C];
  int mgen;
  bit mstable;
  bit mextinct;

  life_engine_param #(.ROWS(16), .COLS(16), .GEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid),
    .load_row(load_row), .load_data(load_data), .step(step), .run(run),
    .wrap_mode(wrap_mode), .board_o(board_o), .generation_cnt_o(gen_o),
    .busy(busy), .done(done), .stable(stable), .extinct(extinct)
  );

  life_engine_param #(.ROWS(16), .COLS(16), .GEN_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid),
    .load_row(load_row), .load_data(load_data), .step(step), .run(run),
    .wrap_mode(wrap_mode), .board_o(board4), .generation_cnt_o(gen4),
    .busy(busy4), .done(done4), .stable(stable4), .extinct(extinct4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] flat();
    logic [255:0] f;
    f = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        f[r*C + c] = m[r][c];
    return f;
  endfunction

  function automatic logic [255:0] cells3(input int r0, input int c0, input int r1,
                                          input int c1, input int r2, input int c2);
    logic [255:0] f;
    f = '0;
    f[r0*C + c0] = 1'b1;
    f[r1*C + c1] = 1'b1;
    f[r2*C + c2] = 1'b1;
    return f;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m[r][c] = 1'b0;
    mgen = 0; mstable = 0; mextinct = 0;
  endtask

  // one Life generation computed directly from neighbour coordinates
  task automatic model_next(input bit w);
    bit nx [R][C];
    int n, rr, cc;
    bit same, empty;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (w) begin
              rr = (rr + R) % R;
              cc = (cc + C) % C;
            end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
              continue;
            end
            n += int'(m[rr][cc]);
          end
        end
        nx[r][c] = (n == 3) || (m[r][c] && n == 2);
      end
    end
    same = 1; empty = 1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        if (nx[r][c] != m[r][c]) same = 0;
        if (nx[r][c]) empty = 0;
        m[r][c] = nx[r][c];
      end
    mstable = same;
    mextinct = empty;
    mgen = (mgen + 1) % 65536;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_board"},   board_o, flat());
    chk({tag, "_gen"},     256'(gen_o), 256'(mgen));
    chk({tag, "_stable"},  256'(stable), 256'(mstable));
    chk({tag, "_extinct"}, 256'(extinct), 256'(mextinct));
    chk({tag, "_board4"},  board4, flat());
    chk({tag, "_gen4"},    256'(gen4), 256'(mgen % 16));
  endtask

  task automatic do_load(input int r, input logic [15:0] d);
    load_valid = 1'b1;
    load_row   = 4'(r);
    load_data  = d;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < C; c++) m[r][c] = d[c];
    mstable = 0; mextinct = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  // waits (bounded) for done; reports cycles waited, busy samples, and any early board change
  task automatic wait_done(input logic [255:0] hold, output int n, output int bcnt,
                           output bit moved);
    n = 0; bcnt = 0; moved = 0;
    while (n < 40) begin
      tick();
      load_valid = 1'b0;
      n++;
      if (busy) bcnt++;
      if (done) break;
      if (board_o !== hold) moved = 1;
    end
  endtask

  task automatic do_step(input string tag, input bit w, input bit inj_load);
    int n, bcnt;
    bit moved;
    logic [255:0] hold;
    hold = flat();
    step = 1'b1;
    wrap_mode = w;
    tick();
    step = 1'b0;
    wrap_mode = ~w;
    bcnt = 0;
    if (inj_load) begin
      load_valid = 1'b1;
      load_row   = 4'd5;
      load_data  = 16'hFFFF;
    end
    wait_done(hold, n, bcnt, moved);
    bcnt += 1;
    chk({tag, "_latency"}, 256'(n), 256'(17));
    chk({tag, "_busy_cycles"}, 256'(bcnt), 256'(17));
    chk({tag, "_no_early_update"}, 256'(moved), 256'(0));
    model_next(w);
    check_all(tag);
    chk({tag, "_busy_after"}, 256'(busy), 256'(0));
  endtask

  task automatic do_run(input string tag, input bit w, input int k);
    int n, bcnt;
    bit moved;
    run = 1'b1;
    wrap_mode = w;
    tick();
    if (k == 1) run = 1'b0;
    for (int g = 0; g < k; g++) begin
      wait_done(flat(), n, bcnt, moved);
      chk({tag, "_spacing"}, 256'(n), 256'(17));
      chk({tag, "_no_early_update"}, 256'(moved), 256'(0));
      model_next(w);
      check_all(tag);
      if (g == k - 2) run = 1'b0;
    end
    chk({tag, "_busy_after"}, 256'(busy), 256'(0));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; clear = 1'b0; load_valid = 1'b0; load_row = '0; load_data = '0;
    step = 1'b0; run = 1'b0; wrap_mode = 1'b0;
    model_clear();
    tick(); tick();
    chk("reset_board", board_o, '0);
    chk("reset_flags", 256'({gen_o, busy, done, stable, extinct}), '0);
    rst_n = 1'b1;
    tick();

    // blinker with dead edges, plus a load during COMPUTE that must be ignored
    do_load(7, 16'h01C0);
    do_step("blink1", 1'b0, 1'b1);
    chk("blink1_shape", board_o, cells3(6, 7, 7, 7, 8, 7));
    do_step("blink2", 1'b0, 1'b0);
    chk("blink2_shape", board_o, cells3(7, 6, 7, 7, 7, 8));
    chk("blink2_gen", 256'(gen_o), 256'(2));

    // edge blinker, toroidal then dead-edge
    do_clear();
    do_load(0, 16'h8003);
    do_step("edge_wrap", 1'b1, 1'b0);
    chk("edge_wrap_shape", board_o, cells3(15, 0, 0, 0, 1, 0));
    do_clear();
    do_load(0, 16'h8003);
    do_step("edge_dead", 1'b0, 1'b0);
    chk("edge_dead_extinct", 256'(extinct), 256'(1));

    // block still life in run mode
    do_clear();
    do_load(3, 16'h0018);
    do_load(4, 16'h0018);
    do_run("block", 1'b0, 3);
    chk("block_stable", 256'(stable), 256'(1));

    // 16 steps to wrap the 4-bit counter
    do_clear();
    do_load(7, 16'h01C0);
    for (int i = 0; i < 16; i++) do_step("gw", 1'b1, 1'b0);
    chk("gen4_wrapped", 256'(gen4), 256'(0));
    chk("gen16_total", 256'(gen_o), 256'(16));

    // clear five cycles into COMPUTE aborts the generation
    do_clear();
    do_load(7, 16'h01C0);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_board", board_o, '0);
    chk("abort_gen", 256'(gen_o), 256'(0));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) seen = 1;
    end
    chk("abort_no_done", 256'(seen), 256'(0));

    // randomized boards, steps and short runs
    for (int it = 0; it < 8; it++) begin
      do_clear();
      for (int r = 0; r < R; r++) do_load(r, 16'($urandom & $urandom));
      if (it % 3 == 2) do_run("rnd_run", 1'($urandom), 2);
      else do_step("rnd_step", 1'($urandom), 1'($urandom));
    end

    // asynchronous reset in the middle of a run
    do_clear();
    do_load(7, 16'h01C0);
    run = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_board", board_o, '0);
    chk("arst_flags", 256'({gen_o, busy, done, stable, extinct}), '0);
    run = 1'b0;
    model_clear();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || done || board_o != '0) seen = 1;
    end
    chk("arst_stays_idle", 256'(seen), 256'(0));
    do_load(2, 16'h0E00);
    do_step("post_rst", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
